booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
- Parametrised, iterative Booth multiplier. Successor to the fixed 32-bit booth block.
- Adds configurable width, per-operation signed/unsigned mode, valid/ready handshakes on both sides, output hold under backpressure and synchronous abort.
- Sits between operand registers and the datapath result bus; one multiplication in flight at a time.

Parameters:
- W, 32: operand width. Must be even and >= 4.
- PW, 2*W: product width (derived; do not override).

Ports:
- CLK  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserts immediately when low; deasserts on the next CLK edge).
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- in_a  in  W  multiplicand.
- in_b  in  W  multiplier.
- in_signed  in  1  1 = two's-complement operands; 0 = unsigned.
- abort  in  1  synchronous cancel of an in-flight operation.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts the product.
- out  out  PW  product.
- busy  out  1  high in CALC.

Behaviour:
- Reset values: in_ready=0 while reset is low, 1 after release (IDLE); out_valid=0; out=0; busy=0. All internal accumulator, counter and state are cleared.
- Operand extension at accept:
  - Both operands are widened to W+2 bits.
  - Sign-extended when in_signed=1; zero-extended when in_signed=0.
  - The product always fits in PW bits.
  - `out` is the exact product: two's complement when signed, unsigned magnitude when unsigned.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. When in_valid=1, the operands are latched, the iteration counter loads N, and the FSM goes to CALC.
  - CALC: one Booth step per cycle. The counter decrements each step. After the step with counter==1, the FSM goes to DONE.
  - DONE: out_valid=1 and `out` is stable. When out_ready=1, the FSM goes to IDLE.
- Radix-2 iteration:
  - N = W+1.
  - Each step examines the multiplier bit pair {b[i], b[i-1]} and adds +A, -A or 0 to the accumulator, followed by an arithmetic right shift of the combined accumulator/multiplier register.
- Latency:
  - Operands are accepted at edge k.
  - out_valid is asserted after edge k+N.
  - Minimum cycle-to-cycle throughput is N+2 cycles (accept, N steps, handoff).
- Backpressure: while DONE and out_ready=0, out_valid and `out` hold indefinitely.
- Input side:
  - in_ready=0 in CALC and DONE.
  - in_valid in those states is ignored; operands are not queued.
- Abort:
  - abort=1 in CALC or DONE forces IDLE on the next edge. out_valid drops, `out` is cleared to 0 and no result is emitted.
  - abort in IDLE is a no-op and has priority over in_valid; nothing is accepted that cycle.
- Output value: `out` is updated only on entry to DONE and holds its value after the handoff until the next DONE entry.
- Reset mid-operation: everything returns to reset values immediately; the partial result is discarded.
- Boundary values that must be exact:
  - signed min*min = +2^(2W-2).
  - unsigned max*max = 2^(2W) - 2^(W+1) + 1.
  - any operand 0 gives 0.

Optional Feature:
- Macro: BOOTH_RADIX4_EN.
- Defined:
  - Modified Booth radix-4 recoding. Each step examines the triplet {b[2i+1], b[2i], b[2i-1]} and selects one of 0, ±A, ±2A, followed by an arithmetic shift of 2.
  - N = (W+2)/2, i.e. 17 for W=32.
  - All handshake and abort rules are unchanged.
- Undefined: radix-2 datapath with N = W+1.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Booth digit enum {ZERO, POS1, NEG1, POS2, NEG2}.
  - Function iter_count(W) returning N for the active radix.
- Sub-module booth_recoder:
  - Combinational.
  - Maps the multiplier bit window to a digit and the selected (possibly negated or doubled) partial product of width W+3.
  - Shared by both radices.

Test Plan (W=32):
- Signed positive × positive: 30×90 -> out=2700; out_valid exactly N cycles after accept.
- Mixed signs, signed mode:
  - 30×-90 -> -2700.
  - -30×90 -> -2700.
  - -30×-90 -> 2700.
- Extremes:
  - Signed 0x80000000×0x80000000 -> 0x4000000000000000.
  - Unsigned 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE00000001.
  - Signed 0xFFFFFFFF×0xFFFFFFFF -> 1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid -> out_valid and out stable, in_ready=0.
  - Raise out_ready -> out_valid drops on the next edge; in_ready=1.
- Abort and reset:
  - abort at CALC step 5 -> IDLE next cycle, out_valid never asserts.
  - reset low mid-CALC -> all outputs 0 asynchronously; next op 7×6 -> 42.
- Back-to-back: in_valid held high with a new operand pair each accept and out_ready=1 -> 8 random signed/unsigned products, each matching the reference model, spaced N+2 cycles.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative Booth multiplier.
// Compile-time option: BOOTH_RADIX4_EN selects modified Booth radix-4 recoding
// (two multiplier bits per step) instead of the default radix-2 datapath.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    NEG1 = 3'd2,
    POS2 = 3'd3,
    NEG2 = 3'd4
  } digit_e;

`ifdef BOOTH_RADIX4_EN
  localparam int unsigned STEP_SHIFT = 2;
`else
  localparam int unsigned STEP_SHIFT = 1;
`endif

  // Number of Booth steps needed to consume a (w+2)-bit extended multiplier.
  function automatic int unsigned iter_count(input int unsigned w);
`ifdef BOOTH_RADIX4_EN
    return (w + 2) / 2;
`else
    return w + 1;
`endif
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Booth digit recoder: maps a 3-bit multiplier window to a digit and the
// matching partial product (0, +-A, +-2A) of width W+3.
// Radix-2 callers feed {b0, b0, b-1}, which only ever yields ZERO/POS1/NEG1.
//   win_i   : multiplier bit window
//   a_i     : extended multiplicand (W+2 bits, two's complement)
//   digit_o : selected Booth digit
//   pp_o    : selected partial product, sign-extended to W+3 bits
module booth_recoder
  import booth_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [2:0]   win_i,
  input  logic [W+1:0] a_i,
  output digit_e       digit_o,
  output logic [W+2:0] pp_o
);

  localparam int unsigned PPW = W + 3;

  logic [PPW-1:0] a1_c;
  logic [PPW-1:0] a2_c;

  assign a1_c = {a_i[W+1], a_i};
  assign a2_c = {a_i, 1'b0};

  // Window decode, then partial product select.
  always_comb begin
    digit_o = ZERO;
    pp_o    = '0;
    case (win_i)
      3'b001, 3'b010: digit_o = POS1;
      3'b011:         digit_o = POS2;
      3'b100:         digit_o = NEG2;
      3'b101, 3'b110: digit_o = NEG1;
      default:        digit_o = ZERO;
    endcase
    case (digit_o)
      POS1:    pp_o = a1_c;
      NEG1:    pp_o = PPW'(~a1_c + PPW'(1));
      POS2:    pp_o = a2_c;
      NEG2:    pp_o = PPW'(~a2_c + PPW'(1));
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative Booth multiplier, one multiplication in flight, valid/ready on
// both sides, result hold under backpressure and synchronous abort.
// Compile-time option: BOOTH_RADIX4_EN (radix-4 steps, N=(W+2)/2); default
// is radix-2 with N=W+1.
//   CLK, reset           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (in_a, in_b, in_signed)
//   abort                : synchronous cancel in CALC/DONE
//   out_valid/out_ready  : product handshake, out = PW-bit product
//   busy                 : high while iterating
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned PW = 2 * W
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic          in_signed,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out,
  output logic          busy
);

  localparam int unsigned EW    = W + 2;
  localparam int unsigned AW    = W + 3;
  localparam int unsigned N     = iter_count(W);
  localparam int unsigned CW    = $clog2(N + 1);
  localparam int unsigned LOWSH = EW - STEP_SHIFT * N;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [EW-1:0]  a_q, a_d;
  logic [EW-1:0]  mul_q, mul_d;
  logic           prev_q, prev_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  out_q, out_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;

  logic [EW-1:0]  a_ext_c;
  logic [EW-1:0]  b_ext_c;
  logic [2:0]     win_c;
  digit_e         digit_c;
  logic [AW-1:0]  pp_c;
  logic [AW-1:0]  sum_c;
  logic [AW-1:0]  step_acc_c;
  logic [EW-1:0]  step_mul_c;
  logic           step_prev_c;
  logic [PW-1:0]  prod_c;

  // Operand widening: sign-extend in signed mode, zero-extend otherwise.
  assign a_ext_c = {{2{in_signed & in_a[W-1]}}, in_a};
  assign b_ext_c = {{2{in_signed & in_b[W-1]}}, in_b};

`ifdef BOOTH_RADIX4_EN
  assign win_c = {mul_q[1], mul_q[0], prev_q};
`else
  assign win_c = {mul_q[0], mul_q[0], prev_q};
`endif

  booth_recoder #(.W(W)) u_recoder (
    .win_i   (win_c),
    .a_i     (a_q),
    .digit_o (digit_c),
    .pp_o    (pp_c)
  );

  assign sum_c = (digit_c == ZERO) ? acc_q : AW'(acc_q + pp_c);

  // Arithmetic right shift of the combined {acc, multiplier} register.
`ifdef BOOTH_RADIX4_EN
  assign step_acc_c  = {{2{sum_c[AW-1]}}, sum_c[AW-1:2]};
  assign step_mul_c  = {sum_c[1:0], mul_q[EW-1:2]};
  assign step_prev_c = mul_q[1];
`else
  assign step_acc_c  = {sum_c[AW-1], sum_c[AW-1:1]};
  assign step_mul_c  = {sum_c[0], mul_q[EW-1:1]};
  assign step_prev_c = mul_q[0];
`endif

  // Unconsumed multiplier bits sit below the product after the final step.
  assign prod_c = PW'({step_acc_c, step_mul_c} >> LOWSH);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    mul_d   = mul_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    out_d   = out_q;

    case (state_q)
      IDLE: begin
        if (!abort && in_ready_q && in_valid) begin
          a_d     = a_ext_c;
          mul_d   = b_ext_c;
          prev_d  = 1'b0;
          acc_d   = '0;
          cnt_d   = CW'(N);
          state_d = CALC;
        end
      end
      CALC: begin
        if (abort) begin
          out_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d  = step_acc_c;
          mul_d  = step_mul_c;
          prev_d = step_prev_c;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            out_d   = prod_c;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          out_d   = '0;
          state_d = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == CALC);
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      mul_q       <= '0;
      prev_q      <= 1'b0;
      acc_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      mul_q       <= mul_d;
      prev_q      <= prev_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (W=32): directed and random products
// are scored through an expected-result queue drained by an output monitor.
module tb_booth_mul_seq;

  localparam int unsigned W  = 32;
  localparam int unsigned PW = 2 * W;
`ifdef BOOTH_RADIX4_EN
  localparam int unsigned N = (W + 2) / 2;
`else
  localparam int unsigned N = W + 1;
`endif

  logic          CLK;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_signed;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  int unsigned   cyc = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] mon_e;

  booth_mul_seq #(.W(W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference: exact product of the widened operands, low PW bits.
  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    logic signed [PW+1:0] ea, eb, p;
    ea = s ? $signed({{(W+2){a[W-1]}}, a}) : $signed({{(W+2){1'b0}}, a});
    eb = s ? $signed({{(W+2){b[W-1]}}, b}) : $signed({{(W+2){1'b0}}, b});
    p  = ea * eb;
    return p[PW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // Monitor: every handoff pops one expected product.
  always @(negedge CLK) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got=%h exp=none", out);
      end else begin
        mon_e = exp_q.pop_front();
        if (out !== mon_e) begin
          errors++;
          $display("FAIL product got=%h exp=%h", out, mon_e);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [PW-1:0] e, input bit push, input bit keep,
                       output int unsigned acc_at);
    int unsigned g = 0;
    while (in_ready !== 1'b1 && g < 4 * N) begin
      @(posedge CLK); #1;
      g++;
    end
    chk1("accept_wait", in_ready, 1'b1);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(posedge CLK); #1;
    acc_at = cyc;
    if (!keep) in_valid = 1'b0;
    if (push) exp_q.push_back(e);
  endtask

  task automatic wait_valid(output int unsigned lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 4 * N) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic drain();
    int unsigned g = 0;
    while (exp_q.size() != 0 && g < 8 * N) begin
      @(posedge CLK); #1;
      g++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0]  ta[8];
    logic [W-1:0]  tb[8];
    logic          ts[8];
    logic [PW-1:0] te[8];
    logic [PW-1:0] e_bp;
    logic [W-1:0]  ra, rb;
    logic          rs;
    logic          seen;
    int unsigned   t, prev_t, lat;

    ta = '{32'd30, 32'hFFFF_FFE2, 32'hFFFF_FFE2, 32'h8000_0000,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hDEAD_BEEF};
    tb = '{32'hFFFF_FFA6, 32'd90, 32'hFFFF_FFA6, 32'h8000_0000,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0};
    ts = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    te = '{64'hFFFF_FFFF_FFFF_F574, 64'hFFFF_FFFF_FFFF_F574, 64'd2700,
           64'h4000_0000_0000_0000, 64'hFFFF_FFFE_0000_0001, 64'd1, 64'd0, 64'd0};

    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out", out, 64'd0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
    chk1("in_ready_before_edge", in_ready, 1'b0);
    @(posedge CLK); #1;
    chk1("in_ready_idle", in_ready, 1'b1);

    // Latency of a plain signed product.
    out_ready = 1'b1;
    issue(32'd30, 32'd90, 1'b1, 64'd2700, 1'b1, 1'b0, t);
    chk1("busy_calc", busy, 1'b1);
    chk1("in_ready_calc", in_ready, 1'b0);
    wait_valid(lat);
    chk("latency", 64'(lat), 64'(N));
    drain();

    // Sign combinations, extremes and zero operands.
    for (int i = 0; i < 8; i++) issue(ta[i], tb[i], ts[i], te[i], 1'b1, 1'b0, t);
    drain();

    // Backpressure: result holds while out_ready is low.
    out_ready = 1'b0;
    e_bp = model(32'h1234_5678, 32'hFEDC_BA98, 1'b0);
    issue(32'h1234_5678, 32'hFEDC_BA98, 1'b0, e_bp, 1'b1, 1'b0, t);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      chk1("bp_valid_hold", out_valid, 1'b1);
      chk("bp_out_hold", out, e_bp);
      chk1("bp_in_ready_low", in_ready, 1'b0);
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    chk1("bp_valid_drop", out_valid, 1'b0);
    chk1("bp_in_ready_back", in_ready, 1'b1);
    chk("bp_out_kept", out, e_bp);
    chk("bp_popped", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of CALC clears outputs without a clock edge.
    issue(32'h0000_ABCD, 32'h0000_1234, 1'b0, '0, 1'b0, 1'b0, t);
    repeat (3) @(posedge CLK);
    #2 reset = 1'b0;
    #1;
    chk1("mid_rst_in_ready", in_ready, 1'b0);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_out", out, 64'd0);
    @(posedge CLK); #1 reset = 1'b1;
    issue(32'd7, 32'd6, 1'b0, 64'd42, 1'b1, 1'b0, t);
    drain();

    // Abort during CALC: back to IDLE, out cleared, nothing emitted.
    issue(32'd1000, 32'd1000, 1'b0, '0, 1'b0, 1'b0, t);
    repeat (4) @(posedge CLK);
    #1;
    chk1("abort_busy_before", busy, 1'b1);
    abort = 1'b1;
    @(posedge CLK); #1 abort = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk("abort_out_cleared", out, 64'd0);
    seen = 1'b0;
    repeat (N + 4) begin
      @(posedge CLK); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk1("abort_no_result", seen, 1'b0);

    // Abort in IDLE wins over in_valid.
    in_a = 32'd5; in_b = 32'd5; in_valid = 1'b1; abort = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; abort = 1'b0;
    chk1("abort_idle_busy", busy, 1'b0);
    chk1("abort_idle_ready", in_ready, 1'b1);

    // Abort while DONE drops the held result.
    out_ready = 1'b0;
    issue(32'd3, 32'd4, 1'b0, '0, 1'b0, 1'b0, t);
    wait_valid(lat);
    chk1("done_reached", out_valid, 1'b1);
    chk("done_out", out, 64'd12);
    abort = 1'b1;
    @(posedge CLK); #1 abort = 1'b0;
    chk1("abort_done_valid", out_valid, 1'b0);
    chk("abort_done_out", out, 64'd0);
    chk1("abort_done_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // Back-to-back random products with in_valid held high.
    prev_t = 0;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs, model(ra, rb, rs), 1'b1, 1'b1, t);
      if (i > 0) chk("b2b_spacing", 64'(t - prev_t), 64'(N + 2));
      prev_t = t;
    end
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
